uart_tx: RTL

- Serial transmitter that sits directly downstream of the baud-tick counter.
- Consumes the counter's single-cycle bit-period tick and shifts a parallel byte out on one line.
- Frame format: start bit, data bits LSB-first, optional parity, stop bit(s).
- Provides a start/busy/done handshake toward the parallel-side controller.

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter driven by an external one-clk bit-period tick.
// Frame: start bit, LSB-first data, optional parity, one or two stop bits; all outputs registered.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bps_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd
);

    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               r_state, w_state_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic [CW-1:0]        r_cnt,   w_cnt_nx;
    logic                 r_par,   w_par_nx;
    logic                 r_txd,   w_txd_nx;
    logic                 r_busy,  w_busy_nx;
    logic                 r_done,  w_done_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_cnt   <= w_cnt_nx;
            r_par   <= w_par_nx;
            r_txd   <= w_txd_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Each branch computes the txd value for the *next* bit so the line stays registered.
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        w_par_nx   = r_par;
        w_txd_nx   = r_txd;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_txd_nx = 1'b1;
                if (tx_start && !r_busy) begin
                    w_state_nx = ARM;
                    w_shift_nx = tx_data;
                    w_par_nx   = (^tx_data) ^ (PARITY_ODD != 0);
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b1;
                end
            end
            ARM: begin
                if (bps_tick) begin
                    w_state_nx = START;
                    w_txd_nx   = 1'b0;
                end
            end
            START: begin
                if (bps_tick) begin
                    w_state_nx = DATA;
                    w_txd_nx   = r_shift[0];
                end
            end
            DATA: begin
                if (bps_tick) begin
                    w_shift_nx = r_shift >> 1;
                    if (r_cnt == CW'(DATA_BITS - 1)) begin
                        w_cnt_nx = '0;
                        if (PARITY_EN != 0) begin
                            w_state_nx = PARITY;
                            w_txd_nx   = r_par;
                        end else begin
                            w_state_nx = STOP;
                            w_txd_nx   = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                        w_txd_nx = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (bps_tick) begin
                    w_state_nx = STOP;
                    w_txd_nx   = 1'b1;
                    w_cnt_nx   = '0;
                end
            end
            STOP: begin
                w_txd_nx = 1'b1;
                if (bps_tick) begin
                    if (r_cnt == CW'(STOP_BITS - 1)) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_txd_nx   = 1'b1;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign txd     = r_txd;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
